mem_port_arbiter: RTL and testbench

//  Shares the single-outstanding rw_* memory port of the AXI master between the

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_port_arbiter_rr_arb2.sv | 29 ++
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states and transaction owner.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IB = 1'b0,
    OWN_DB = 1'b1
  } owner_t;

  localparam int REQ_IB = 0;
  localparam int REQ_DB = 1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-request round-robin picker: a tie goes to whichever requester was not granted last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last,
  input  logic       en,
  output logic [1:0] gnt,
  output owner_t     next_last
);

  always_comb begin
    gnt       = 2'b00;
    next_last = last;
    if (en) begin
      if (req[REQ_IB] && req[REQ_DB]) begin
        gnt = (last == OWN_IB) ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
      if (gnt[REQ_DB]) begin
        next_last = OWN_DB;
      end else if (gnt[REQ_IB]) begin
        next_last = OWN_IB;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-outstanding memory port between instruction fetch (ib) and load/store (db).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ib_req_i,
  input  logic [ADDR_WIDTH-1:0]   ib_addr_i,
  input  logic [2:0]              ib_size_i,
  output logic                    ib_ready_o,
  output logic [DATA_WIDTH-1:0]   ib_rdata_o,
  output logic [1:0]              ib_resp_o,
  input  logic                    db_req_i,
  input  logic                    db_wen_i,
  input  logic [ADDR_WIDTH-1:0]   db_addr_i,
  input  logic [2:0]              db_size_i,
  input  logic [DATA_WIDTH-1:0]   db_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] db_wmask_i,
  output logic                    db_ready_o,
  output logic [DATA_WIDTH-1:0]   db_rdata_o,
  output logic [1:0]              db_resp_o,
  output logic                    mem_cen_o,
  output logic                    mem_wen_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [2:0]              mem_size_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
  input  logic                    mem_ready_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic [1:0]              mem_resp_i
);

  state_t     state, state_next;
  owner_t     owner, last_owner, next_last;
  logic [1:0] gnt;
  logic       busy;

  rr_arb2 u_rr_arb2 (
    .req       ({db_req_i, ib_req_i}),
    .last      (last_owner),
    .en        (state == IDLE),
    .gnt       (gnt),
    .next_last (next_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // RELEASE always lasts one cycle so the downstream FSMs can leave their DONE state.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (|gnt) state_next = BUSY;
      BUSY:    if (mem_ready_i) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= OWN_IB;
      last_owner  <= OWN_IB;
      mem_cen_o   <= 1'b0;
      mem_wen_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_size_o  <= '0;
      mem_wdata_o <= '0;
      mem_wmask_o <= '0;
    end else begin
      mem_cen_o  <= (state_next != IDLE);
      last_owner <= next_last;
      if (gnt[REQ_DB]) begin
        owner       <= OWN_DB;
        mem_wen_o   <= db_wen_i;
        mem_addr_o  <= db_addr_i;
        mem_size_o  <= db_size_i;
        mem_wdata_o <= db_wdata_i;
        mem_wmask_o <= db_wmask_i;
      end else if (gnt[REQ_IB]) begin
        owner       <= OWN_IB;
        mem_wen_o   <= 1'b0;
        mem_addr_o  <= ib_addr_i;
        mem_size_o  <= ib_size_i;
        mem_wdata_o <= '0;
        mem_wmask_o <= '0;
      end
    end
  end

  // A ready outside BUSY is dropped, so the requesters never see a stray pulse.
  assign busy       = (state == BUSY);
  assign ib_ready_o = mem_ready_i & busy & (owner == OWN_IB);
  assign db_ready_o = mem_ready_i & busy & (owner == OWN_DB);
  assign ib_rdata_o = mem_rdata_i;
  assign ib_resp_o  = mem_resp_i;
  assign db_rdata_o = mem_rdata_i;
  assign db_resp_o  = mem_resp_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus hand-written latency and reset sequences.
module tb_mem_port_arbiter;

  localparam logic [63:0] IB_ADDR  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] DB_ADDR  = 64'h0000_0000_0000_0100;
  localparam logic [63:0] DB_WDATA = 64'h0000_0000_DEAD_BEEF;
  localparam logic [7:0]  DB_WMASK = 8'h0F;
  localparam logic [63:0] RDATA    = 64'h1122_3344_5566_7788;
  localparam logic [1:0]  RESP     = 2'b01;

  // fld: 0 = fields not checked, 1 = all zero, 2 = ib fields, 3 = db read, 4 = db write
  typedef struct {
    logic       rst, ib_req, db_req, db_wen, mem_ready;
    logic       exp_cen, exp_ib_ready, exp_db_ready;
    logic [2:0] fld;
  } vec_t;

  logic        clk, rst;
  logic        ib_req, ib_ready, db_req, db_wen, db_ready;
  logic        mem_cen, mem_wen, mem_ready;
  logic [63:0] ib_rdata, db_rdata, mem_addr, mem_wdata;
  logic [2:0]  mem_size;
  logic [7:0]  mem_wmask;
  logic [1:0]  ib_resp, db_resp;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  mem_port_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .ib_req_i    (ib_req),
    .ib_addr_i   (IB_ADDR),
    .ib_size_i   (3'd2),
    .ib_ready_o  (ib_ready),
    .ib_rdata_o  (ib_rdata),
    .ib_resp_o   (ib_resp),
    .db_req_i    (db_req),
    .db_wen_i    (db_wen),
    .db_addr_i   (DB_ADDR),
    .db_size_i   (3'd3),
    .db_wdata_i  (DB_WDATA),
    .db_wmask_i  (DB_WMASK),
    .db_ready_o  (db_ready),
    .db_rdata_o  (db_rdata),
    .db_resp_o   (db_resp),
    .mem_cen_o   (mem_cen),
    .mem_wen_o   (mem_wen),
    .mem_addr_o  (mem_addr),
    .mem_size_o  (mem_size),
    .mem_wdata_o (mem_wdata),
    .mem_wmask_o (mem_wmask),
    .mem_ready_i (mem_ready),
    .mem_rdata_i (RDATA),
    .mem_resp_i  (RESP)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic r, ib, db, wen, rdy, cen, ibr, dbr,
                              input logic [2:0] fld);
    vec_t v;
    v.rst = r; v.ib_req = ib; v.db_req = db; v.db_wen = wen; v.mem_ready = rdy;
    v.exp_cen = cen; v.exp_ib_ready = ibr; v.exp_db_ready = dbr; v.fld = fld;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst       = v.rst;
    ib_req    = v.ib_req;
    db_req    = v.db_req;
    db_wen    = v.db_wen;
    mem_ready = v.mem_ready;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVector(input int i, input vec_t v);
    string tag;
    tag = $sformatf("row%0d", i);
    checkOutput({tag, " cen"}, 64'(mem_cen), 64'(v.exp_cen));
    checkOutput({tag, " ib_ready"}, 64'(ib_ready), 64'(v.exp_ib_ready));
    checkOutput({tag, " db_ready"}, 64'(db_ready), 64'(v.exp_db_ready));
    if (v.exp_ib_ready) begin
      checkOutput({tag, " ib_rdata"}, ib_rdata, RDATA);
      checkOutput({tag, " ib_resp"}, 64'(ib_resp), 64'(RESP));
    end
    if (v.exp_db_ready) begin
      checkOutput({tag, " db_rdata"}, db_rdata, RDATA);
      checkOutput({tag, " db_resp"}, 64'(db_resp), 64'(RESP));
    end
    case (v.fld)
      3'd1: begin
        checkOutput({tag, " wen"}, 64'(mem_wen), 64'd0);
        checkOutput({tag, " addr"}, mem_addr, 64'd0);
        checkOutput({tag, " size"}, 64'(mem_size), 64'd0);
        checkOutput({tag, " wdata"}, mem_wdata, 64'd0);
        checkOutput({tag, " wmask"}, 64'(mem_wmask), 64'd0);
      end
      3'd2: begin
        checkOutput({tag, " wen"}, 64'(mem_wen), 64'd0);
        checkOutput({tag, " addr"}, mem_addr, IB_ADDR);
        checkOutput({tag, " size"}, 64'(mem_size), 64'd2);
        checkOutput({tag, " wmask"}, 64'(mem_wmask), 64'd0);
      end
      3'd3, 3'd4: begin
        checkOutput({tag, " wen"}, 64'(mem_wen), (v.fld == 3'd4) ? 64'd1 : 64'd0);
        checkOutput({tag, " addr"}, mem_addr, DB_ADDR);
        checkOutput({tag, " size"}, 64'(mem_size), 64'd3);
        checkOutput({tag, " wdata"}, mem_wdata, DB_WDATA);
        checkOutput({tag, " wmask"}, 64'(mem_wmask), 64'(DB_WMASK));
      end
      default: ;
    endcase
  endtask

  initial begin
    int  lat;
    bit  found;

    //            rst ib db wen rdy  cen ibr dbr fld
    vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 1));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0, 2));
    vecs.push_back(mk(0, 1, 0, 0, 1,  1, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0,  1, 0, 0, 4));
    vecs.push_back(mk(0, 0, 1, 1, 1,  1, 0, 1, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 4));
    vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0,  1, 0, 0, 3));
    vecs.push_back(mk(0, 1, 1, 0, 1,  1, 0, 1, 3));
    vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0, 3));
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,  1, 0, 0, 2));
    vecs.push_back(mk(0, 1, 1, 0, 1,  1, 1, 0, 2));
    vecs.push_back(mk(0, 0, 1, 0, 0,  1, 0, 0, 2));
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,  1, 0, 0, 3));
    vecs.push_back(mk(0, 1, 1, 0, 1,  1, 0, 1, 3));
    vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0, 3));
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,  1, 0, 0, 2));
    vecs.push_back(mk(0, 1, 1, 0, 1,  1, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0));

    rst = 1'b1; ib_req = 1'b0; db_req = 1'b0; db_wen = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkVector(i, vecs[i]);
      step();
    end

    // db request arrives while ib owns the port; it must wait for RELEASE and IDLE
    ib_req = 1'b1;
    step();
    db_req = 1'b1;
    db_wen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t4 ib cen", 64'(mem_cen), 64'd1);
      checkOutput("t4 ib addr stable", mem_addr, IB_ADDR);
      checkOutput("t4 ib wen stable", 64'(mem_wen), 64'd0);
      step();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("t4 ib ready", 64'(ib_ready), 64'd1);
    checkOutput("t4 db ready quiet", 64'(db_ready), 64'd0);
    step();
    mem_ready = 1'b0;
    ib_req    = 1'b0;
    found = 1'b0;
    lat   = 0;
    for (int k = 1; k <= 8 && !found; k++) begin
      @(negedge clk);
      if (mem_cen && mem_addr == DB_ADDR) begin
        found = 1'b1;
        lat   = k;
      end
      step();
    end
    checkOutput("t4 db cen latency", 64'(lat), 64'd3);
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("t4 db ready", 64'(db_ready), 64'd1);
    checkOutput("t4 db wen", 64'(mem_wen), 64'd1);
    step();
    mem_ready = 1'b0;
    db_req    = 1'b0;
    db_wen    = 1'b0;
    step();
    step();

    // reset in the middle of an ib transaction aborts it without a ready pulse
    ib_req = 1'b1;
    step();
    @(negedge clk);
    checkOutput("t6 busy cen", 64'(mem_cen), 64'd1);
    step();
    rst = 1'b1;
    step();
    rst       = 1'b0;
    ib_req    = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("t6 cen after rst", 64'(mem_cen), 64'd0);
    checkOutput("t6 ib ready after rst", 64'(ib_ready), 64'd0);
    checkOutput("t6 db ready after rst", 64'(db_ready), 64'd0);
    step();
    mem_ready = 1'b0;
    db_req    = 1'b1;
    step();
    @(negedge clk);
    checkOutput("t6 new req cen", 64'(mem_cen), 64'd1);
    checkOutput("t6 new req addr", mem_addr, DB_ADDR);
    checkOutput("t6 new req wen", 64'(mem_wen), 64'd0);
    step();
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("t6 new req ready", 64'(db_ready), 64'd1);
    step();
    mem_ready = 1'b0;
    db_req    = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
